// File: rtl/mul_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: sequencing states,
// datapath width, multiplier latency and mode encodings.
package mul_pkg;

  localparam int unsigned MUL_W = 16;
  localparam int unsigned MUL_ISSUE_TO_RESULT = 2;

  localparam logic MODE_FP  = 1'b1;
  localparam logic MODE_INT = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD1 = 2'd1,
    HOLD2 = 2'd2,
    WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/mul_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  logic [ID_W-1:0] cand;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = ID_W'((32'(ptr) + i) % N_REQ);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    gnt = any ? (N_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one int_fp_mul between N_REQ requesters; holds operands stable from
// issue to result capture and returns products on a registered valid/ready channel.
module mul_share_arbiter
  import mul_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0]       req_mode,
  input  logic [MUL_W*N_REQ-1:0] req_a,
  input  logic [MUL_W*N_REQ-1:0] req_b,
  output logic                   mul_mode,
  output logic [MUL_W-1:0]       mul_a,
  output logic [MUL_W-1:0]       mul_b,
  input  logic [MUL_W-1:0]       mul_c,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [MUL_W-1:0]       rsp_data
);

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   op_id;
  logic [N_REQ-1:0]  win_gnt;
  logic [ID_W-1:0]   win_idx;
  logic              win_any;
  logic              accept;
  logic              capture;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state; grants only from IDLE or on a WAIT edge that captures
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (win_any) begin
          accept    = 1'b1;
          state_nxt = HOLD1;
        end
      end
      HOLD1: state_nxt = HOLD2;
      HOLD2: state_nxt = WAIT;
      WAIT: begin
        if (!rsp_valid || rsp_ready) begin
          capture = 1'b1;
          if (win_any) begin
            accept    = 1'b1;
            state_nxt = HOLD1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant is masked while reset is asserted so nothing looks accepted
  assign req_ready = (accept && rst) ? win_gnt : '0;

  // Op registers feed the multiplier and move only on accept edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a    <= '0;
      mul_b    <= '0;
      mul_mode <= MODE_INT;
      op_id    <= '0;
      rr_ptr   <= '0;
    end else if (accept) begin
      mul_a    <= req_a[32'(win_idx)*MUL_W +: MUL_W];
      mul_b    <= req_b[32'(win_idx)*MUL_W +: MUL_W];
      mul_mode <= req_mode[win_idx];
      op_id    <= win_idx;
      rr_ptr   <= ID_W'((32'(win_idx) + 32'd1) % N_REQ);
    end
  end

  // Response register; a capture on a hand-off edge keeps valid high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else if (capture) begin
      rsp_valid <= 1'b1;
      rsp_id    <= op_id;
      rsp_data  <= mul_c;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
